// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: byte/pair register indices, the F and A slots,
// and the default writable-flag mask.
package cpu_pkg;

  typedef enum logic [2:0] {
    REG_B = 3'd0,
    REG_C = 3'd1,
    REG_D = 3'd2,
    REG_E = 3'd3,
    REG_H = 3'd4,
    REG_L = 3'd5,
    REG_F = 3'd6,
    REG_A = 3'd7
  } reg_idx_t;

  typedef enum logic [1:0] {
    PAIR_BC    = 2'd0,
    PAIR_DE    = 2'd1,
    PAIR_HL    = 2'd2,
    PAIR_SP_AF = 2'd3
  } pair_idx_t;

  localparam logic [2:0] REG_F_IDX = 3'd6;
  localparam logic [2:0] REG_A_IDX = 3'd7;

  localparam logic [7:0] FLAG_MASK_DEFAULT = 8'hF0;

  // For index 3 these return the AF bytes; callers route the SP case themselves.
  function automatic reg_idx_t pair_hi_idx(input pair_idx_t p);
    return (p == PAIR_SP_AF) ? reg_idx_t'(REG_A_IDX) : reg_idx_t'({p, 1'b0});
  endfunction

  function automatic reg_idx_t pair_lo_idx(input pair_idx_t p);
    return (p == PAIR_SP_AF) ? reg_idx_t'(REG_F_IDX) : reg_idx_t'({p, 1'b1});
  endfunction

endpackage

// File: rtl/pair_step_unit.sv
// Combinational +/-1 on a W-bit pair with natural modulo-2^W wrap.
// Shared between the register-file step path and the PC/IDU path.
module pair_step_unit #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_value,
  input  logic         i_dec,
  output logic [W-1:0] o_next
);

  localparam logic [W-1:0] ONE = W'(1);

  assign o_next = i_dec ? (i_value - ONE) : (i_value + ONE);

endmodule

// File: rtl/reg_file_pairs.sv
// CPU register file B,C,D,E,H,L,F,A plus SP with byte, pair and step writers.
// Define REG_FILE_BYPASS_EN to forward next-edge values onto all read ports.
module reg_file_pairs
  import cpu_pkg::*;
#(
  parameter int                  DATA_W    = 8,
  parameter int                  NUM_RD    = 2,
  parameter logic [DATA_W-1:0]   FLAG_MASK = DATA_W'(FLAG_MASK_DEFAULT),
  parameter logic [2*DATA_W-1:0] SP_RST    = 16'hFFFE
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [3*NUM_RD-1:0]      i_rd_sel,
  output logic [DATA_W*NUM_RD-1:0] o_rd_data,
  input  logic                     i_wr_en,
  input  logic [2:0]               i_wr_sel,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [1:0]               i_prd_sel,
  input  logic                     i_prd_af,
  output logic [2*DATA_W-1:0]      o_prd_data,
  input  logic                     i_pwr_en,
  input  logic [1:0]               i_pwr_sel,
  input  logic                     i_pwr_af,
  input  logic [2*DATA_W-1:0]      i_pwr_data,
  input  logic                     i_step_en,
  input  logic [1:0]               i_step_sel,
  input  logic                     i_step_dec,
  output logic [2*DATA_W-1:0]      o_step_next
);

  localparam int PAIR_W = 2 * DATA_W;

  logic [DATA_W-1:0] regs_reg  [8];
  logic [DATA_W-1:0] regs_next [8];
  logic [PAIR_W-1:0] sp_reg;
  logic [PAIR_W-1:0] sp_next;

  logic [DATA_W-1:0] rd_view [8];
  logic [PAIR_W-1:0] sp_view;

  pair_idx_t         step_idx;
  pair_idx_t         pwr_idx;
  pair_idx_t         prd_idx;
  logic [PAIR_W-1:0] step_cur;

  assign step_idx = pair_idx_t'(i_step_sel);
  assign pwr_idx  = pair_idx_t'(i_pwr_sel);
  assign prd_idx  = pair_idx_t'(i_prd_sel);

  // Step index 3 always means SP, never AF.
  assign step_cur = (step_idx == PAIR_SP_AF) ? sp_reg
                  : {regs_reg[pair_hi_idx(step_idx)], regs_reg[pair_lo_idx(step_idx)]};

  pair_step_unit #(
    .W (PAIR_W)
  ) u_step (
    .i_value (step_cur),
    .i_dec   (i_step_dec),
    .o_next  (o_step_next)
  );

  // Writers are layered lowest priority first so each later writer overrides
  // only the bytes it actually targets.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_next[i] = regs_reg[i];
    end
    sp_next = sp_reg;

    if (i_step_en) begin
      if (step_idx == PAIR_SP_AF) begin
        sp_next = o_step_next;
      end else begin
        regs_next[pair_hi_idx(step_idx)] = o_step_next[PAIR_W-1:DATA_W];
        regs_next[pair_lo_idx(step_idx)] = o_step_next[DATA_W-1:0];
      end
    end

    if (i_pwr_en) begin
      if (pwr_idx == PAIR_SP_AF && !i_pwr_af) begin
        sp_next = i_pwr_data;
      end else begin
        regs_next[pair_hi_idx(pwr_idx)] = i_pwr_data[PAIR_W-1:DATA_W];
        regs_next[pair_lo_idx(pwr_idx)] =
          (pair_lo_idx(pwr_idx) == REG_F_IDX) ? (i_pwr_data[DATA_W-1:0] & FLAG_MASK)
                                              : i_pwr_data[DATA_W-1:0];
      end
    end

    if (i_wr_en) begin
      regs_next[i_wr_sel] = (i_wr_sel == REG_F_IDX) ? (i_wr_data & FLAG_MASK) : i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_reg[i] <= '0;
      end
      sp_reg <= SP_RST;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_reg[i] <= regs_next[i];
      end
      sp_reg <= sp_next;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Nothing commits while reset is held, so forward the reset state then.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rd_view[i] = i_rst ? regs_reg[i] : regs_next[i];
    end
    sp_view = i_rst ? sp_reg : sp_next;
  end
`else
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rd_view[i] = regs_reg[i];
    end
    sp_view = sp_reg;
  end
`endif

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
    assign o_rd_data[DATA_W*gi +: DATA_W] = rd_view[i_rd_sel[3*gi +: 3]];
  end

  assign o_prd_data = (prd_idx == PAIR_SP_AF && !i_prd_af) ? sp_view
                    : {rd_view[pair_hi_idx(prd_idx)], rd_view[pair_lo_idx(prd_idx)]};

endmodule

// File: tb/tb_reg_file_pairs.sv
// Self-checking bench for reg_file_pairs: randomized run against a per-byte
// priority model, a directed vector table, and reset/bypass sequences.
module tb_reg_file_pairs;

  localparam int DATA_W = 8;
  localparam int NUM_RD = 2;
`ifdef REG_FILE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        i_clk;
  logic        i_rst;
  logic [5:0]  i_rd_sel;
  logic [15:0] o_rd_data;
  logic        i_wr_en;
  logic [2:0]  i_wr_sel;
  logic [7:0]  i_wr_data;
  logic [1:0]  i_prd_sel;
  logic        i_prd_af;
  logic [15:0] o_prd_data;
  logic        i_pwr_en;
  logic [1:0]  i_pwr_sel;
  logic        i_pwr_af;
  logic [15:0] i_pwr_data;
  logic        i_step_en;
  logic [1:0]  i_step_sel;
  logic        i_step_dec;
  logic [15:0] o_step_next;

  reg_file_pairs #(
    .DATA_W (DATA_W),
    .NUM_RD (NUM_RD)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_sel    (i_rd_sel),
    .o_rd_data   (o_rd_data),
    .i_wr_en     (i_wr_en),
    .i_wr_sel    (i_wr_sel),
    .i_wr_data   (i_wr_data),
    .i_prd_sel   (i_prd_sel),
    .i_prd_af    (i_prd_af),
    .o_prd_data  (o_prd_data),
    .i_pwr_en    (i_pwr_en),
    .i_pwr_sel   (i_pwr_sel),
    .i_pwr_af    (i_pwr_af),
    .i_pwr_data  (i_pwr_data),
    .i_step_en   (i_step_en),
    .i_step_sel  (i_step_sel),
    .i_step_dec  (i_step_dec),
    .o_step_next (o_step_next)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte registers as ints, SP as one int; destination 8 = SP.
  int m_reg[8];
  int m_sp;
  int nx_reg[8];
  int nx_sp;

  typedef struct {
    int dest;
    int val;
    int prio;
  } bw_t;
  bw_t wq[$];

  function automatic int get_pair(input int sel, input int af, input int use_next);
    int hi;
    int lo;
    if (sel == 3 && af == 0) return (use_next != 0) ? nx_sp : m_sp;
    if (sel == 3) begin
      hi = 7;
      lo = 6;
    end else begin
      hi = 2 * sel;
      lo = 2 * sel + 1;
    end
    if (use_next != 0) return nx_reg[hi] * 256 + nx_reg[lo];
    return m_reg[hi] * 256 + m_reg[lo];
  endfunction

  function automatic int model_step(input int sel, input int dec);
    int v;
    v = get_pair(sel, 0, 0);
    return (dec != 0) ? (v + 65535) % 65536 : (v + 1) % 65536;
  endfunction

  function automatic void push_pair(input int sel, input int af, input int v, input int prio);
    if (sel == 3 && af == 0) begin
      wq.push_back('{8, v, prio});
    end else if (sel == 3) begin
      wq.push_back('{7, v / 256, prio});
      wq.push_back('{6, (v % 256) & 'hF0, prio});
    end else begin
      wq.push_back('{2 * sel, v / 256, prio});
      wq.push_back('{2 * sel + 1, v % 256, prio});
    end
  endfunction

  // Each destination byte (or SP) takes the value of its highest-priority writer.
  task automatic model_eval();
    int best[9];
    wq.delete();
    if (i_step_en) push_pair(int'(i_step_sel), 0, model_step(int'(i_step_sel), int'(i_step_dec)), 1);
    if (i_pwr_en) push_pair(int'(i_pwr_sel), int'(i_pwr_af), int'(i_pwr_data), 2);
    if (i_wr_en) wq.push_back('{int'(i_wr_sel), (i_wr_sel == 3'd6) ? int'(i_wr_data) & 'hF0 : int'(i_wr_data), 3});
    foreach (best[i]) best[i] = 0;
    nx_reg = m_reg;
    nx_sp  = m_sp;
    foreach (wq[j]) begin
      if (wq[j].prio > best[wq[j].dest]) begin
        best[wq[j].dest] = wq[j].prio;
        if (wq[j].dest == 8) nx_sp = wq[j].val;
        else nx_reg[wq[j].dest] = wq[j].val;
      end
    end
  endtask

  task automatic model_reset();
    foreach (m_reg[i]) m_reg[i] = 0;
    m_sp = 'hFFFE;
  endtask

  task automatic idle_inputs();
    i_wr_en   = 1'b0;
    i_pwr_en  = 1'b0;
    i_step_en = 1'b0;
  endtask

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        pwr_en;
    logic [1:0]  pwr_sel;
    logic        pwr_af;
    logic [15:0] pwr_data;
    logic        step_en;
    logic [1:0]  step_sel;
    logic        step_dec;
    logic [2:0]  rs0;
    logic [2:0]  rs1;
    logic [1:0]  psel;
    logic        paf;
    logic [7:0]  e_rd0;
    logic [7:0]  e_rd1;
    logic [15:0] e_prd;
    logic        chk_step;
    logic [15:0] e_step;
  } vec_t;

  vec_t vecs[16];

  task automatic run_row(input int idx, input vec_t v);
    i_wr_en    = v.wr_en;
    i_wr_sel   = v.wr_sel;
    i_wr_data  = v.wr_data;
    i_pwr_en   = v.pwr_en;
    i_pwr_sel  = v.pwr_sel;
    i_pwr_af   = v.pwr_af;
    i_pwr_data = v.pwr_data;
    i_step_en  = v.step_en;
    i_step_sel = v.step_sel;
    i_step_dec = v.step_dec;
    i_rd_sel   = {v.rs1, v.rs0};
    i_prd_sel  = v.psel;
    i_prd_af   = v.paf;
    @(negedge i_clk);
    if (v.chk_step) check($sformatf("row%0d step_next", idx), 32'(o_step_next), 32'(v.e_step));
    @(posedge i_clk);
    #1;
    idle_inputs();
    @(negedge i_clk);
    check($sformatf("row%0d rd0", idx), 32'(o_rd_data[7:0]), 32'(v.e_rd0));
    check($sformatf("row%0d rd1", idx), 32'(o_rd_data[15:8]), 32'(v.e_rd1));
    check($sformatf("row%0d prd", idx), 32'(o_prd_data), 32'(v.e_prd));
    $display("row %0d: rd0=%h rd1=%h prd=%h step=%h", idx, o_rd_data[7:0], o_rd_data[15:8],
             o_prd_data, o_step_next);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pd;
    i_rst = 1'b1;
    idle_inputs();
    i_wr_sel = 3'd0; i_wr_data = 8'h00;
    i_pwr_sel = 2'd0; i_pwr_af = 1'b0; i_pwr_data = 16'h0000;
    i_step_sel = 2'd3; i_step_dec = 1'b0;
    i_rd_sel = {3'd0, 3'd7};
    i_prd_sel = 2'd3; i_prd_af = 1'b0;

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset rd0", 32'(o_rd_data[7:0]), 32'h00);
    check("reset rd1", 32'(o_rd_data[15:8]), 32'h00);
    check("reset sp", 32'(o_prd_data), 32'hFFFE);
    check("reset step_next", 32'(o_step_next), 32'hFFFF);
    i_prd_af = 1'b1;
    #1;
    check("reset af", 32'(o_prd_data), 32'h0000);
    $display("reset: sp=FFFE checked");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();

    // Randomized run against the model
    for (int t = 0; t < 300; t++) begin
      i_wr_en    = ($urandom_range(0, 2) == 0);
      i_wr_sel   = 3'($urandom_range(0, 7));
      i_wr_data  = 8'($urandom);
      i_pwr_en   = ($urandom_range(0, 2) == 0);
      i_pwr_sel  = 2'($urandom_range(0, 3));
      i_pwr_af   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: pd = 16'h0000;
        1: pd = 16'hFFFF;
        default: pd = 16'($urandom);
      endcase
      i_pwr_data = pd;
      i_step_en  = ($urandom_range(0, 1) == 0);
      i_step_sel = 2'($urandom_range(0, 3));
      i_step_dec = 1'($urandom_range(0, 1));
      i_rd_sel   = 6'($urandom);
      i_prd_sel  = 2'($urandom_range(0, 3));
      i_prd_af   = 1'($urandom_range(0, 1));
      model_eval();
      @(negedge i_clk);
      for (int k = 0; k < NUM_RD; k++) begin
        check($sformatf("rand%0d rd%0d", t, k), 32'(o_rd_data[8*k +: 8]),
              32'((BYP != 0) ? nx_reg[i_rd_sel[3*k +: 3]] : m_reg[i_rd_sel[3*k +: 3]]));
      end
      check($sformatf("rand%0d prd", t), 32'(o_prd_data),
            32'(get_pair(int'(i_prd_sel), int'(i_prd_af), BYP)));
      check($sformatf("rand%0d step_next", t), 32'(o_step_next),
            32'(model_step(int'(i_step_sel), int'(i_step_dec))));
      $display("txn %0d: wr=%0b/%0d pwr=%0b/%0d step=%0b/%0d prd=%h step_next=%h", t,
               i_wr_en, i_wr_sel, i_pwr_en, i_pwr_sel, i_step_en, i_step_sel, o_prd_data, o_step_next);
      @(posedge i_clk);
      m_reg = nx_reg;
      m_sp  = nx_sp;
      #1;
    end

    // Directed vector table from a fresh reset
    idle_inputs();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    vecs[0]  = '{1'b1, 3'd7, 8'h3C, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0,
                 3'd7, 3'd6, 2'd3, 1'b1, 8'h3C, 8'h00, 16'h3C00, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 3'd6, 8'hFF, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0,
                 3'd6, 3'd7, 2'd3, 1'b1, 8'hF0, 8'h3C, 16'h3CF0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 2'd1, 1'b0, 16'hBEEF, 1'b0, 2'd0, 1'b0,
                 3'd2, 3'd3, 2'd1, 1'b0, 8'hBE, 8'hEF, 16'hBEEF, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 2'd3, 1'b0, 16'h1234, 1'b0, 2'd0, 1'b0,
                 3'd7, 3'd6, 2'd3, 1'b0, 8'h3C, 8'hF0, 16'h1234, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 2'd3, 1'b1, 16'h5A5F, 1'b0, 2'd0, 1'b0,
                 3'd7, 3'd6, 2'd3, 1'b1, 8'h5A, 8'h50, 16'h5A50, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 2'd2, 1'b0, 16'hFFFF, 1'b0, 2'd0, 1'b0,
                 3'd4, 3'd5, 2'd2, 1'b0, 8'hFF, 8'hFF, 16'hFFFF, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 2'd2, 1'b0,
                 3'd4, 3'd5, 2'd2, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 16'h0000};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0,
                 3'd0, 3'd1, 2'd3, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 2'd3, 1'b1,
                 3'd0, 3'd1, 2'd3, 1'b0, 8'h00, 8'h00, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[9]  = '{1'b1, 3'd5, 8'h11, 1'b1, 2'd2, 1'b0, 16'hAABB, 1'b1, 2'd2, 1'b0,
                 3'd4, 3'd5, 2'd2, 1'b0, 8'hAA, 8'h11, 16'hAA11, 1'b1, 16'h0001};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 2'd0, 1'b0, 16'h1234, 1'b1, 2'd0, 1'b1,
                 3'd0, 3'd1, 2'd0, 1'b0, 8'h12, 8'h34, 16'h1234, 1'b1, 16'hFFFF};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b1, 2'd0, 1'b0, 16'h0102, 1'b1, 2'd1, 1'b0,
                 3'd2, 3'd3, 2'd1, 1'b0, 8'hBE, 8'hF0, 16'hBEF0, 1'b1, 16'hBEF0};
    vecs[12] = '{1'b1, 3'd0, 8'h77, 1'b1, 2'd0, 1'b0, 16'hAAAA, 1'b0, 2'd0, 1'b0,
                 3'd0, 3'd1, 2'd0, 1'b0, 8'h77, 8'hAA, 16'h77AA, 1'b0, 16'h0000};
    vecs[13] = '{1'b1, 3'd6, 8'h0F, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0,
                 3'd6, 3'd7, 2'd3, 1'b1, 8'h00, 8'h5A, 16'h5A00, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 2'd0, 1'b0,
                 3'd0, 3'd1, 2'd0, 1'b0, 8'h77, 8'hAB, 16'h77AB, 1'b1, 16'h77AB};
    vecs[15] = '{1'b0, 3'd0, 8'h00, 1'b1, 2'd3, 1'b0, 16'hABCD, 1'b1, 2'd3, 1'b0,
                 3'd6, 3'd7, 2'd3, 1'b0, 8'h00, 8'h5A, 16'hABCD, 1'b1, 16'h0000};
    for (int r = 0; r < 16; r++) begin
      run_row(r, vecs[r]);
    end

    // Write-to-read visibility on read port 1
    i_wr_en = 1'b1; i_wr_sel = 3'd1; i_wr_data = 8'h22;
    @(posedge i_clk);
    #1;
    idle_inputs();
    @(posedge i_clk);
    #1;
    i_wr_en = 1'b1; i_wr_sel = 3'd1; i_wr_data = 8'h77;
    i_rd_sel = {3'd1, 3'd0};
    @(negedge i_clk);
    check("bypass same-cycle C", 32'(o_rd_data[15:8]), (BYP != 0) ? 32'h77 : 32'h22);
    @(posedge i_clk);
    #1;
    idle_inputs();
    @(negedge i_clk);
    check("bypass next-cycle C", 32'(o_rd_data[15:8]), 32'h77);
    $display("bypass: C=%h", o_rd_data[15:8]);
    @(posedge i_clk);
    #1;

    // Reset asserted mid-cycle during a pending write to B
    i_wr_en = 1'b1; i_wr_sel = 3'd0; i_wr_data = 8'h99;
    i_pwr_en = 1'b1; i_pwr_sel = 2'd3; i_pwr_af = 1'b0; i_pwr_data = 16'h1234;
    @(posedge i_clk);
    #1;
    i_pwr_en = 1'b0;
    i_wr_data = 8'h55;
    i_rd_sel = {3'd7, 3'd0};
    i_prd_sel = 2'd3; i_prd_af = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    check("async rst B", 32'(o_rd_data[7:0]), 32'h00);
    check("async rst A", 32'(o_rd_data[15:8]), 32'h00);
    check("async rst sp", 32'(o_prd_data), 32'hFFFE);
    @(posedge i_clk);
    #1;
    check("rst held B", 32'(o_rd_data[7:0]), 32'h00);
    idle_inputs();
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("post rst B", 32'(o_rd_data[7:0]), 32'h00);
    check("post rst sp", 32'(o_prd_data), 32'hFFFE);
    $display("reset mid-write: B=%h sp=%h", o_rd_data[7:0], o_prd_data);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
